// File: rtl/note_pkg.sv
// Note table and shared types for the tone receive path.
package note_pkg;

  localparam int NUM_NOTE_ENTRIES = 8;
  localparam int NOTE_IDX_W       = 3;

  // Expected square-wave periods in clk cycles at 100 MHz, C4 up to C5.
  localparam logic [0:NUM_NOTE_ENTRIES-1][31:0] NOTE_PERIOD = '{
    32'd382219,  // C4
    32'd340524,  // D4
    32'd303370,  // E4
    32'd286344,  // F4
    32'd255102,  // G4
    32'd227273,  // A4
    32'd202478,  // B4
    32'd191110   // C5
  };

  typedef enum logic [1:0] {
    IDLE,
    ACQUIRE,
    LOCKED
  } state_e;

endpackage

// File: rtl/edge_sync.sv
// Brings the asynchronous tone line into the clk domain and turns each
// rising transition into a single-cycle pulse, three cycles after the input
// changes: two synchronizer stages plus a registered edge detect.
module edge_sync (
  input  logic clk,
  input  logic reset,
  input  logic async_i,
  output logic pulse_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;
  logic pulse_q;

  // Synchronizer chain and registered rising-edge detect.
  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q  <= 1'b0;
      sync_q  <= 1'b0;
      prev_q  <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      meta_q  <= async_i;
      sync_q  <= meta_q;
      prev_q  <= sync_q;
      pulse_q <= sync_q & ~prev_q;
    end
  end

  assign pulse_o = pulse_q;

endmodule

// File: rtl/note_detector.sv
// Measures the period of an incoming square wave, matches it against the
// note table and reports a note index once it has been stable for a few
// consecutive periods.
module note_detector
  import note_pkg::*;
#(
  parameter int CNT_W     = 20,
  parameter int TOL_CLKS  = 4000,
  parameter int STABLE    = 3,
  parameter int NUM_NOTES = 8,
  parameter logic [0:NUM_NOTES-1][31:0] NOTE_TABLE = NOTE_PERIOD
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  tone_in,
  output logic                  note_valid,
  output logic [NOTE_IDX_W-1:0] note_idx,
  output logic                  note_strobe,
  output logic [CNT_W-1:0]      period_out
);

  localparam int STB_W = $clog2(STABLE + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic                  tonePulse;
  logic                  timeout;

  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [CNT_W-1:0]      period_q;
  state_e                state_q, state_d;
  logic                  candValid_q, candValid_d;
  logic [NOTE_IDX_W-1:0] candIdx_q, candIdx_d;
  logic [STB_W-1:0]      stable_q, stable_d;
  logic                  valid_q, valid_d;
  logic [NOTE_IDX_W-1:0] idx_q, idx_d;
  logic                  strobe_q, strobe_d;

  logic                  hit;
  logic [NOTE_IDX_W-1:0] hitIdx;
  logic [CNT_W:0]        diff;
  logic [CNT_W:0]        absDiff;

  edge_sync uEdgeSync (
    .clk     (clk),
    .reset   (reset),
    .async_i (tone_in),
    .pulse_o (tonePulse)
  );

  // A saturated counter means no edge for the longest measurable period.
  assign timeout = (cnt_q == CNT_MAX);

  // Period counter restarts at 1 on each edge and otherwise counts up to saturation.
  always_comb begin
    cnt_d = cnt_q;
    if (tonePulse) begin
      cnt_d = CNT_W'(1);
    end else if (!timeout) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Lowest table entry within tolerance of the period just measured.
  always_comb begin
    hit     = 1'b0;
    hitIdx  = '0;
    diff    = '0;
    absDiff = '0;
    for (int i = 0; i < NUM_NOTES; i++) begin
      diff    = {1'b0, cnt_q} - (CNT_W+1)'(NOTE_TABLE[NOTE_IDX_W'(i)]);
      absDiff = diff[CNT_W] ? -diff : diff;
      if (!hit && (absDiff <= (CNT_W+1)'(TOL_CLKS))) begin
        hit    = 1'b1;
        hitIdx = NOTE_IDX_W'(i);
      end
    end
  end

  // Lock FSM: track a candidate note and lock after enough matching periods.
  always_comb begin
    state_d     = state_q;
    candValid_d = candValid_q;
    candIdx_d   = candIdx_q;
    stable_d    = stable_q;
    valid_d     = valid_q;
    idx_d       = idx_q;
    strobe_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (tonePulse) begin
          state_d = ACQUIRE;
        end
      end
      ACQUIRE: begin
        if (tonePulse) begin
          if (hit && candValid_q && (hitIdx == candIdx_q)) begin
            stable_d = stable_q + STB_W'(1);
          end else if (hit) begin
            candValid_d = 1'b1;
            candIdx_d   = hitIdx;
            stable_d    = STB_W'(1);
          end else begin
            candValid_d = 1'b0;
            stable_d    = '0;
          end
          if (stable_d == STB_W'(STABLE)) begin
            state_d  = LOCKED;
            valid_d  = 1'b1;
            idx_d    = candIdx_d;
            strobe_d = 1'b1;
          end
        end else if (timeout) begin
          state_d     = IDLE;
          candValid_d = 1'b0;
          stable_d    = '0;
          valid_d     = 1'b0;
          idx_d       = '0;
        end
      end
      LOCKED: begin
        if (tonePulse) begin
          if (!(hit && (hitIdx == candIdx_q))) begin
            state_d     = ACQUIRE;
            candValid_d = hit;
            candIdx_d   = hitIdx;
            stable_d    = hit ? STB_W'(1) : '0;
            valid_d     = 1'b0;
            idx_d       = '0;
          end
        end else if (timeout) begin
          state_d     = IDLE;
          candValid_d = 1'b0;
          stable_d    = '0;
          valid_d     = 1'b0;
          idx_d       = '0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, counter and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q       <= '0;
      period_q    <= '0;
      state_q     <= IDLE;
      candValid_q <= 1'b0;
      candIdx_q   <= '0;
      stable_q    <= '0;
      valid_q     <= 1'b0;
      idx_q       <= '0;
      strobe_q    <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      if (tonePulse) begin
        period_q <= cnt_q;
      end
      state_q     <= state_d;
      candValid_q <= candValid_d;
      candIdx_q   <= candIdx_d;
      stable_q    <= stable_d;
      valid_q     <= valid_d;
      idx_q       <= idx_d;
      strobe_q    <= strobe_d;
    end
  end

  assign note_valid  = valid_q;
  assign note_idx    = idx_q;
  assign note_strobe = strobe_q;
  assign period_out  = period_q;

endmodule
